// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared state encoding and bus-level constants for the I2C target.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ACK_ADDR = 3'd2,
        ST_REG      = 3'd3,
        ST_ACK_REG  = 3'd4,
        ST_DATA     = 3'd5,
        ST_ACK_DATA = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_t;

    localparam logic c_ACK       = 1'b0;
    localparam logic c_NACK      = 1'b1;
    localparam logic c_I2C_WRITE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : SCL/SDA synchronisers with edge, START and STOP pulse detection.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det,
    output logic o_sda
);

    logic r_scl_meta, r_scl_sync, r_scl_hist;
    logic r_sda_meta, r_sda_sync, r_sda_hist;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_rise = r_scl_sync & ~r_scl_hist;
    assign w_scl_fall = ~r_scl_sync & r_scl_hist;
    assign w_start    = r_scl_sync & r_scl_hist & ~r_sda_sync & r_sda_hist;
    assign w_stop     = r_scl_sync & r_scl_hist & r_sda_sync & ~r_sda_hist;

    // Lines reset to the idle-high level so no spurious event fires after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_meta  <= 1'b1;
            r_scl_sync  <= 1'b1;
            r_scl_hist  <= 1'b1;
            r_sda_meta  <= 1'b1;
            r_sda_sync  <= 1'b1;
            r_sda_hist  <= 1'b1;
            o_scl_rise  <= 1'b0;
            o_scl_fall  <= 1'b0;
            o_start_det <= 1'b0;
            o_stop_det  <= 1'b0;
            o_sda       <= 1'b1;
        end else begin
            r_scl_meta  <= i_scl;
            r_scl_sync  <= r_scl_meta;
            r_scl_hist  <= r_scl_sync;
            r_sda_meta  <= i_sda;
            r_sda_sync  <= r_sda_meta;
            r_sda_hist  <= r_sda_sync;
            o_scl_rise  <= w_scl_rise;
            o_scl_fall  <= w_scl_fall;
            o_start_det <= w_start;
            o_stop_det  <= w_stop;
            o_sda       <= r_sda_sync;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_slave_reg_receiver.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_reg_receiver
// Description : Write-only I2C target that turns frames into register strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_reg_receiver
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h40,
    parameter int         AUTO_INC   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_en,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_busy
);

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
    i2c_state_t r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_reg_ptr;
    logic       r_byte_done;
    logic       w_in_byte;
    logic       w_addr_hit;

    i2c_line_sync u_line_sync (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_scl       (i_scl),
        .i_sda       (i_sda),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start),
        .o_stop_det  (w_stop),
        .o_sda       (w_sda)
    );

    assign w_in_byte  = (r_state == ST_ADDR) || (r_state == ST_REG) || (r_state == ST_DATA);
    assign w_addr_hit = (r_shift[7:1] == SLAVE_ADDR) && (r_shift[0] == c_I2C_WRITE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_reg_ptr   <= 8'd0;
            r_byte_done <= 1'b0;
            o_sda_oe    <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= 8'd0;
            o_wr_data   <= 8'd0;
            o_busy      <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            if (w_start) begin
                r_state     <= ST_ADDR;
                r_bit_cnt   <= 3'd0;
                r_byte_done <= 1'b0;
                o_sda_oe    <= 1'b0;
                o_busy      <= 1'b1;
            end else if (w_stop) begin
                r_state     <= ST_IDLE;
                r_bit_cnt   <= 3'd0;
                r_byte_done <= 1'b0;
                o_sda_oe    <= 1'b0;
                o_busy      <= 1'b0;
            end else if (w_scl_rise) begin
                r_shift   <= {r_shift[6:0], w_sda};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_in_byte && (r_bit_cnt == 3'd7)) begin
                    r_byte_done <= 1'b1;
                end
            end else if (w_scl_fall) begin
                // Byte decisions and ACK release both happen on SCL low, never while SCL is high.
                unique case (r_state)
                    ST_ADDR: begin
                        if (r_byte_done) begin
                            r_byte_done <= 1'b0;
                            if (w_addr_hit) begin
                                o_sda_oe <= 1'b1;
                                r_state  <= ST_ACK_ADDR;
                            end else begin
                                r_state  <= ST_IGNORE;
                            end
                        end
                    end
                    ST_REG: begin
                        if (r_byte_done) begin
                            r_byte_done <= 1'b0;
                            r_reg_ptr   <= r_shift;
                            o_sda_oe    <= 1'b1;
                            r_state     <= ST_ACK_REG;
                        end
                    end
                    ST_DATA: begin
                        if (r_byte_done) begin
                            r_byte_done <= 1'b0;
                            o_wr_en     <= 1'b1;
                            o_wr_addr   <= r_reg_ptr;
                            o_wr_data   <= r_shift;
                            if (AUTO_INC != 0) begin
                                r_reg_ptr <= r_reg_ptr + 8'd1;
                            end
                            o_sda_oe    <= 1'b1;
                            r_state     <= ST_ACK_DATA;
                        end
                    end
                    ST_ACK_ADDR, ST_ACK_REG, ST_ACK_DATA: begin
                        o_sda_oe  <= 1'b0;
                        r_bit_cnt <= 3'd0;
                        r_state   <= (r_state == ST_ACK_ADDR) ? ST_REG : ST_DATA;
                    end
                    default: begin
                        o_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave_reg_receiver.md
Name: i2c_slave_reg_receiver

Overview:
- I2C target (slave) receiver; the responder end for the team's I2C write-frame initiator.
- Frame decoded: START, 7-bit slave address, W bit, register address byte, one or more data bytes, STOP.
- Drives ACK on SDA and emits one-cycle register write strobes (address/data) into a local register file or peripheral.
- Write-only target: reads are NACKed.

Parameters:
- SLAVE_ADDR, 7'h40, 7-bit address this target answers to.
- AUTO_INC, 1, 1 = register address increments after each data byte in a frame; 0 = address held.

Ports:
- i_clk  in  1  system clock; must be ≥ 10× SCL frequency.
- i_rst  in  1  asynchronous, active-high reset.
- i_scl  in  1  I2C SCL line, asynchronous to i_clk.
- i_sda  in  1  I2C SDA line input, asynchronous.
- o_sda_oe  out  1  1 = pull SDA low (open-drain ACK); 0 = release.
- o_wr_en  out  1  one-cycle write strobe.
- o_wr_addr  out  8  register address for o_wr_en.
- o_wr_data  out  8  data byte for o_wr_en.
- o_busy  out  1  high from START until STOP, or until reset.

Behaviour:
- Reset values: o_sda_oe=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, state=IDLE, bit counter=0, shift register=0.
- Line sampling: i_scl and i_sda each pass through a 2-flop synchroniser plus one history flop. Edge and condition events are 1-cycle pulses, 3 cycles after the line change.
  - scl_rise, scl_fall: SCL edges.
  - START: SDA falling while SCL high.
  - STOP: SDA rising while SCL high.
- Bit reception: on scl_rise, shift sda into the shift register MSB-first and increment the 3-bit bit counter. Data is never sampled on scl_fall.
- States: IDLE, ADDR, ACK_ADDR, REG, ACK_REG, DATA, ACK_DATA, IGNORE.
- START, in any state (including repeated START): go to ADDR, clear the bit counter, o_sda_oe=0, o_busy=1.
- STOP, in any state: go to IDLE, o_sda_oe=0, o_busy=0. No write is issued for a partial byte.
- ADDR: after the 8th scl_rise, wait for the following scl_fall, then compare shift[7:1] with SLAVE_ADDR and check shift[0]=0.
  - Match and write: o_sda_oe=1, go to ACK_ADDR.
  - Otherwise: o_sda_oe stays 0 (NACK), go to IGNORE.
- ACK_x states: o_sda_oe stays 1 through the 9th SCL high period. It is released on the 9th scl_fall, at which point the bit counter clears and the FSM moves to the next byte state.
  - ACK_ADDR → REG.
  - ACK_REG → DATA.
  - ACK_DATA → DATA.
- REG: after 8 bits, on scl_fall, latch the register pointer = shift and ACK. No write strobe is issued.
- DATA: after 8 bits, on scl_fall:
  - o_wr_en=1 for exactly one cycle, with o_wr_addr = pointer and o_wr_data = shift.
  - Assert ACK.
  - Pointer increments (mod 256, 0xFF wraps to 0x00) when AUTO_INC=1.
- o_wr_addr and o_wr_data hold their values after the strobe until the next strobe.
- IGNORE: o_sda_oe held 0; leave only on START or STOP.
- Simultaneous START/STOP with scl edges cannot occur; START/STOP take priority over scl_rise/fall in the same cycle.
- o_sda_oe changes only on the cycle of a scl_fall event, START, STOP, or reset. It never changes while synchronised SCL is high.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The FSM ignores the bus until the next START.

Decomposition:
- Shared package i2c_pkg:
  - state encoding for the 8 states;
  - ACK=1'b0 / NACK=1'b1 line constants;
  - I2C_WRITE=1'b0 constant.
- Sub-module i2c_line_sync: synchronisers, history flops, and the scl_rise, scl_fall, start_det, stop_det pulse outputs. It is reusable by a future I2C initiator-side monitor.

Test Plan:
- START, addr 0x40+W, reg 0x05, data 0xA5, STOP:
  - SDA pulled low on all three 9th clocks;
  - single o_wr_en pulse with o_wr_addr=0x05, o_wr_data=0xA5;
  - o_busy falls after STOP.
- Address 0x41+W: no ACK (o_sda_oe never 1), no o_wr_en, FSM in IGNORE until STOP.
- Address 0x40+R (R/W=1): NACK on 9th clock; subsequent bytes ignored.
- Reg 0xFE, data 0x11, 0x22, 0x33 with AUTO_INC=1: strobes at 0xFE/0x11, 0xFF/0x22, 0x00/0x33.
- Repeated START after 4 data bits, then full frame reg 0x10 data 0x5A: partial byte dropped; one strobe at 0x10/0x5A.
- i_rst asserted during ACK_DATA while o_sda_oe=1: o_sda_oe=0 and o_busy=0 asynchronously. No strobe until the next complete frame is ACKed.
